// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_JAL      = 4'd10,
    S_BEQ      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    CLS_LOAD    = 3'd0,
    CLS_STORE   = 3'd1,
    CLS_RTYPE   = 3'd2,
    CLS_ITYPE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_JAL     = 3'd5,
    CLS_ILLEGAL = 3'd6
  } op_class_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/op_class_decoder.sv
// Combinational opcode classifier: immediate format, instruction class and legality.
module op_class_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] i_op,
  output logic [1:0] o_imm_src,
  output op_class_t  o_op_class,
  output logic       o_legal
);

  // Opcode to class/immediate lookup
  always_comb begin
    o_imm_src  = IMM_I;
    o_op_class = CLS_ILLEGAL;
    o_legal    = 1'b1;
    case (i_op)
      OP_LOAD:   o_op_class = CLS_LOAD;
      OP_STORE:  begin o_op_class = CLS_STORE;  o_imm_src = IMM_S; end
      OP_RTYPE:  o_op_class = CLS_RTYPE;
      OP_ITYPE:  o_op_class = CLS_ITYPE;
      OP_BRANCH: begin o_op_class = CLS_BRANCH; o_imm_src = IMM_B; end
      OP_JAL:    begin o_op_class = CLS_JAL;    o_imm_src = IMM_J; end
      default:   o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback
// over a shared datapath and a single memory port.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int RESET_PC_HOLD = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic [1:0]       imm_src,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] instret
);

  localparam logic [3:0] HOLD_INIT = 4'(RESET_PC_HOLD);

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_hold;
  logic [CNT_W-1:0] r_instret;
  logic             r_illegal;
  logic [1:0]       w_imm_dec;
  op_class_t        w_class;
  logic             w_legal;
  logic             w_pc_update;
  logic             w_branch;
  logic             w_retire;

  op_class_decoder u_dec (
    .i_op       (op),
    .o_imm_src  (w_imm_dec),
    .o_op_class (w_class),
    .o_legal    (w_legal)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RESET;
    else        r_state <= w_next_state;
  end

  // Post-reset idle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    r_hold <= HOLD_INIT;
    else if (r_state == S_RESET && r_hold != 4'd0) r_hold <= r_hold - 4'd1;
    else                                           r_hold <= r_hold;
  end

  assign w_retire = (w_next_state == S_FETCH) &&
                    (r_state inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ});

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + CNT_W'(1);
    else               r_instret <= r_instret;
  end

  // Sticky trap flag, raised as the FSM enters TRAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_illegal <= 1'b0;
    else        r_illegal <= r_illegal | (w_next_state == S_TRAP);
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RESET:    if (r_hold <= 4'd1) w_next_state = S_FETCH; else w_next_state = S_RESET;
      S_FETCH:    if (mem_ready) w_next_state = S_DECODE; else w_next_state = S_FETCH;
      S_DECODE: begin
        case (w_class)
          CLS_LOAD, CLS_STORE: w_next_state = S_MEMADR;
          CLS_RTYPE:           w_next_state = S_EXECR;
          CLS_ITYPE:           w_next_state = S_EXECI;
          CLS_BRANCH:          w_next_state = S_BEQ;
          CLS_JAL:             w_next_state = S_JAL;
          default:             w_next_state = S_TRAP;
        endcase
        if (!w_legal) w_next_state = S_TRAP;
        else          w_next_state = w_next_state;
      end
      // op may have moved since DECODE; anything but a memory op is treated as illegal
      S_MEMADR: begin
        if (w_class == CLS_LOAD)       w_next_state = S_MEMREAD;
        else if (w_class == CLS_STORE) w_next_state = S_MEMWRITE;
        else                           w_next_state = S_TRAP;
      end
      S_MEMREAD:  if (mem_ready) w_next_state = S_MEMWB; else w_next_state = S_MEMREAD;
      S_MEMWB:    w_next_state = S_FETCH;
      S_MEMWRITE: if (mem_ready) w_next_state = S_FETCH; else w_next_state = S_MEMWRITE;
      S_EXECR:    w_next_state = S_ALUWB;
      S_EXECI:    w_next_state = S_ALUWB;
      S_ALUWB:    w_next_state = S_FETCH;
      S_JAL:      w_next_state = S_ALUWB;
      S_BEQ:      w_next_state = S_FETCH;
      S_TRAP:     w_next_state = S_TRAP;
      default:    w_next_state = S_TRAP;
    endcase
  end

  // Moore control decode; only pc_write and the fetch strobes see live inputs
  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_REGB;
    alu_op      = ALUOP_ADD;
    result_src  = RES_ALUOUT;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req     = 1'b1;
        alu_src_b   = SRCB_FOUR;
        result_src  = RES_ALURES;
        ir_write    = mem_ready;
        w_pc_update = mem_ready;
      end
      S_DECODE:   begin alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_IMM; end
      S_MEMADR:   begin alu_src_a = SRCA_REGA;  alu_src_b = SRCB_IMM; end
      S_MEMREAD:  begin mem_req = 1'b1; adr_src = 1'b1; end
      S_MEMWB:    begin result_src = RES_DATA; reg_write = 1'b1; end
      S_MEMWRITE: begin mem_req = 1'b1; mem_write = 1'b1; adr_src = 1'b1; end
      S_EXECR:    begin alu_src_a = SRCA_REGA; alu_op = ALUOP_FUNCT; end
      S_EXECI:    begin alu_src_a = SRCA_REGA; alu_src_b = SRCB_IMM; alu_op = ALUOP_FUNCT; end
      S_ALUWB:    reg_write = 1'b1;
      S_JAL:      begin alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_FOUR; w_pc_update = 1'b1; end
      S_BEQ:      begin alu_src_a = SRCA_REGA; alu_op = ALUOP_SUB; w_branch = 1'b1; end
      default:    mem_req = 1'b0;
    endcase
    pc_write = w_pc_update | (w_branch & zero);
    if (r_state == S_RESET || r_state == S_TRAP) imm_src = IMM_I;
    else                                         imm_src = w_imm_dec;
  end

  assign illegal_instr = r_illegal;
  assign instret       = r_instret;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle expected control vectors via a scoreboard queue.
module tb_multicycle_controller;

  localparam int B_RST = 0, B_FETCH = 1, B_DECODE = 2, B_MEMADR = 3, B_MEMREAD = 4,
                 B_MEMWB = 5, B_MEMWRITE = 6, B_EXECR = 7, B_EXECI = 8, B_ALUWB = 9,
                 B_JAL = 10, B_BEQ = 11, B_TRAP = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  op = 7'b0110011;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal_instr;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src, imm_src;
  logic [31:0] instret;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [1:0]  exp_imm_g = 2'b00;
  logic [16:0] exp_q[$];

  multicycle_controller #(.CNT_W(32), .RESET_PC_HOLD(1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .imm_src(imm_src),
    .illegal_instr(illegal_instr), .instret(instret)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] exp_vec(int st, logic mr, logic z, logic [1:0] imm);
    logic mreq = 1'b0, mw = 1'b0, adr = 1'b0, irw = 1'b0, pcw = 1'b0, rw = 1'b0, ill = 1'b0;
    logic [1:0] a = 2'b00, b = 2'b00, ao = 2'b00, rs = 2'b00, im;
    case (st)
      B_FETCH:    begin mreq = 1'b1; b = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
      B_DECODE:   begin a = 2'b01; b = 2'b01; end
      B_MEMADR:   begin a = 2'b10; b = 2'b01; end
      B_MEMREAD:  begin mreq = 1'b1; adr = 1'b1; end
      B_MEMWB:    begin rs = 2'b01; rw = 1'b1; end
      B_MEMWRITE: begin mreq = 1'b1; mw = 1'b1; adr = 1'b1; end
      B_EXECR:    begin a = 2'b10; ao = 2'b10; end
      B_EXECI:    begin a = 2'b10; b = 2'b01; ao = 2'b10; end
      B_ALUWB:    rw = 1'b1;
      B_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
      B_BEQ:      begin a = 2'b10; ao = 2'b01; pcw = z; end
      B_TRAP:     ill = 1'b1;
      default:    ill = 1'b0;
    endcase
    im = (st == B_RST || st == B_TRAP) ? 2'b00 : imm;
    return {mreq, mw, adr, irw, pcw, rw, a, b, ao, rs, im, ill};
  endfunction

  // One clock: drive inputs, queue the expected vector, compare at the falling edge.
  task automatic step(input int st, input logic mr, input logic z, input string tag);
    logic [16:0] got, e;
    mem_ready = mr;
    zero = z;
    exp_q.push_back(exp_vec(st, mr, z, exp_imm_g));
    @(negedge clk);
    got = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal_instr};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_errors++;
      $display("FAIL %s cyc=%0d st=%0d got=%b exp=%b", tag, cyc, st, got, e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_instret(input logic [31:0] e, input string tag);
    n_checks++;
    if (instret !== e) begin
      n_errors++;
      $display("FAIL %s instret got=%0d exp=%0d", tag, instret, e);
    end
  endtask

  task automatic do_reset(input logic [6:0] o, input logic [1:0] imm);
    op = o;
    exp_imm_g = imm;
    rst_n = 1'b0;
    step(B_RST, 1'b1, 1'b0, "reset_low");
    step(B_RST, 1'b1, 1'b1, "reset_low");
    check_instret(32'd0, "reset_low");
    rst_n = 1'b1;
    step(B_RST, 1'b1, 1'b0, "reset_hold");
  endtask

  task automatic test_reset_rtype();
    do_reset(7'b0110011, 2'b00);
    step(B_FETCH, 1'b1, 1'b0, "rtype");
    step(B_DECODE, 1'b1, 1'b0, "rtype");
    step(B_EXECR, 1'b1, 1'b0, "rtype");
    check_instret(32'd0, "rtype_pre");
    step(B_ALUWB, 1'b1, 1'b0, "rtype");
    check_instret(32'd1, "rtype_post");
    step(B_FETCH, 1'b1, 1'b0, "rtype");
  endtask

  task automatic test_load();
    do_reset(7'b0000011, 2'b00);
    for (int i = 0; i < 3; i++) step(B_FETCH, 1'b0, 1'b1, "lw_fetch_wait");
    step(B_FETCH, 1'b1, 1'b0, "lw");
    op = 7'b1101111; // op changes outside DECODE/MEMADR only affect imm_src
    exp_imm_g = 2'b11;
    op = 7'b0000011;
    exp_imm_g = 2'b00;
    step(B_DECODE, 1'b0, 1'b0, "lw");
    step(B_MEMADR, 1'b1, 1'b0, "lw");
    for (int i = 0; i < 2; i++) step(B_MEMREAD, 1'b0, 1'b0, "lw_mem_wait");
    step(B_MEMREAD, 1'b1, 1'b0, "lw");
    step(B_MEMWB, 1'b0, 1'b0, "lw");
    check_instret(32'd1, "lw");
    step(B_FETCH, 1'b0, 1'b0, "lw");
  endtask

  task automatic test_store();
    do_reset(7'b0100011, 2'b01);
    step(B_FETCH, 1'b1, 1'b0, "sw");
    step(B_DECODE, 1'b1, 1'b0, "sw");
    step(B_MEMADR, 1'b1, 1'b0, "sw");
    step(B_MEMWRITE, 1'b0, 1'b0, "sw_wait");
    check_instret(32'd0, "sw_wait");
    step(B_MEMWRITE, 1'b1, 1'b0, "sw");
    check_instret(32'd1, "sw");
    step(B_FETCH, 1'b0, 1'b0, "sw");
  endtask

  task automatic test_beq();
    do_reset(7'b1100011, 2'b10);
    step(B_FETCH, 1'b1, 1'b1, "beq_taken");
    step(B_DECODE, 1'b1, 1'b1, "beq_taken");
    step(B_BEQ, 1'b0, 1'b1, "beq_taken");
    check_instret(32'd1, "beq_taken");
    step(B_FETCH, 1'b1, 1'b0, "beq_not");
    step(B_DECODE, 1'b1, 1'b0, "beq_not");
    step(B_BEQ, 1'b1, 1'b0, "beq_not");
    check_instret(32'd2, "beq_not");
  endtask

  task automatic test_jal();
    do_reset(7'b1101111, 2'b11);
    step(B_FETCH, 1'b1, 1'b0, "jal");
    step(B_DECODE, 1'b0, 1'b0, "jal");
    step(B_JAL, 1'b0, 1'b0, "jal");
    step(B_ALUWB, 1'b0, 1'b0, "jal");
    check_instret(32'd1, "jal");
    step(B_FETCH, 1'b0, 1'b0, "jal");
  endtask

  task automatic test_back_to_back();
    do_reset(7'b0010011, 2'b00);
    step(B_FETCH, 1'b1, 1'b0, "itype");
    step(B_DECODE, 1'b1, 1'b0, "itype");
    step(B_EXECI, 1'b1, 1'b0, "itype");
    step(B_ALUWB, 1'b1, 1'b0, "itype");
    op = 7'b0100011;
    exp_imm_g = 2'b01;
    step(B_FETCH, 1'b1, 1'b0, "b2b_sw");
    step(B_DECODE, 1'b1, 1'b0, "b2b_sw");
    step(B_MEMADR, 1'b1, 1'b0, "b2b_sw");
    step(B_MEMWRITE, 1'b1, 1'b0, "b2b_sw");
    check_instret(32'd2, "b2b");
  endtask

  task automatic test_trap_and_async_reset();
    do_reset(7'b1111111, 2'b00);
    step(B_FETCH, 1'b1, 1'b0, "trap");
    step(B_DECODE, 1'b1, 1'b0, "trap");
    for (int i = 0; i < 100; i++) begin
      op = 7'($urandom_range(0, 127));
      step(B_TRAP, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "trap_hold");
    end
    check_instret(32'd0, "trap");
    do_reset(7'b0100011, 2'b01);
    step(B_FETCH, 1'b1, 1'b0, "pre_sw");
    step(B_DECODE, 1'b1, 1'b0, "pre_sw");
    step(B_MEMADR, 1'b1, 1'b0, "pre_sw");
    step(B_MEMWRITE, 1'b1, 1'b0, "pre_sw");
    op = 7'b0000011;
    exp_imm_g = 2'b00;
    step(B_FETCH, 1'b1, 1'b0, "mid_lw");
    step(B_DECODE, 1'b1, 1'b0, "mid_lw");
    step(B_MEMADR, 1'b0, 1'b0, "mid_lw");
    step(B_MEMREAD, 1'b0, 1'b0, "mid_lw");
    check_instret(32'd1, "mid_lw");
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_errors++;
      $display("FAIL memread_req got=%b exp=1", mem_req);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, ir_write, pc_write, reg_write, illegal_instr} !== 5'b00000 || instret !== 32'd0) begin
      n_errors++;
      $display("FAIL async_reset got=%b instret=%0d exp=00000 instret=0",
               {mem_req, ir_write, pc_write, reg_write, illegal_instr}, instret);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset_rtype();
    test_load();
    test_store();
    test_beq();
    test_jal();
    test_back_to_back();
    test_trap_and_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
